alu_issue_ctl: RTL and testbench

//  Initiator side of the 32-bit ALU interface. Accepts one decoded instruction
//    (opcode/funct fields plus operand values) per valid/ready handshake.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_op_decode.sv | 48 ++++
 rtl/alu_issue_ctl.sv | 99 +++++++++
 tb/tb_alu_issue_ctl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, RISC-V opcodes and issue FSM states shared by the ALU issue path
package alu_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [6:0] OPC_R  = 7'h33;
    localparam logic [6:0] OPC_I  = 7'h13;
    localparam logic [6:0] OPC_LD = 7'h03;
    localparam logic [6:0] OPC_ST = 7'h23;
    localparam logic [6:0] OPC_BR = 7'h63;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps opcode/funct3/funct7 to ALU op, operand-b select and branch flags
// BRANCH_BNE_EN makes branch funct3=001 (BNE) legal with an inverted taken sense.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] op,
    output logic       use_imm,
    output logic       is_branch,
    output logic       br_inv,
    output logic       illegal
);
    logic unused_f7;
    assign unused_f7 = ^{funct7[6], funct7[4:0]};
    always_comb begin
        op = ALU_ADD;
        use_imm = 1'b0;
        is_branch = 1'b0;
        br_inv = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_R, OPC_I: begin
                use_imm = opcode == OPC_I;
                case (funct3)
                    3'b000: op = (opcode == OPC_R && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b111: op = ALU_AND;
                    3'b110: op = ALU_OR;
                    3'b010: op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LD, OPC_ST: use_imm = 1'b1;
            OPC_BR: begin
                op = ALU_SUB;
                is_branch = 1'b1;
`ifdef BRANCH_BNE_EN
                br_inv = funct3 == 3'b001;
                illegal = funct3 != 3'b000 && funct3 != 3'b001;
`else
                illegal = funct3 != 3'b000;
`endif
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_issue_ctl.sv
// alu_issue_ctl: issues one decoded instruction to the ALU and returns its result on a handshake
// BRANCH_BNE_EN (see alu_op_decode) enables BNE.
module alu_issue_ctl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [DATA_W-1:0] in_rs1,
    input  logic [DATA_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_taken,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  ops_done
);
    state_t     state;
    logic [2:0] d_op;
    logic       d_imm, d_br, d_inv, d_ill, br_q, inv_q;

    alu_op_decode u_dec (
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .op       (d_op),
        .use_imm  (d_imm),
        .is_branch(d_br),
        .br_inv   (d_inv),
        .illegal  (d_ill)
    );

    assign in_ready = state == IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= ALU_AND;
            out_valid <= 1'b0;
            out_result <= '0;
            out_zero <= 1'b0;
            out_taken <= 1'b0;
            out_illegal <= 1'b0;
            ops_done <= '0;
            br_q <= 1'b0;
            inv_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (d_ill) begin
                        out_result <= '0;
                        out_zero <= 1'b0;
                        out_taken <= 1'b0;
                        out_illegal <= 1'b1;
                        out_valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        alu_a <= in_rs1;
                        alu_b <= d_imm ? in_imm : in_rs2;
                        alu_op <= d_op;
                        br_q <= d_br;
                        inv_q <= d_inv;
                        out_illegal <= 1'b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    out_result <= alu_z;
                    out_zero <= alu_zero;
                    out_taken <= br_q & (alu_zero ^ inv_q);
                    out_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= IDLE;
                    if (!out_illegal && !(&ops_done)) ops_done <= ops_done + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctl.sv
// tb_alu_issue_ctl: directed checks of alu_issue_ctl driving a behavioural ALU
module tb_alu_issue_ctl;
    localparam int CW = 4;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, alu_zero, out_valid, out_zero, out_taken, out_illegal;
    logic [6:0]  in_opcode = '0, in_funct7 = '0;
    logic [2:0]  in_funct3 = '0, alu_op;
    logic [31:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0, alu_a, alu_b, alu_z, out_result;
    logic [CW-1:0] ops_done;
    int checks = 0, errors = 0, exp_ops = 0;

    always #5 clk = ~clk;

    alu_issue_ctl #(.DATA_W(32), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_taken(out_taken), .out_illegal(out_illegal),
        .ops_done(ops_done)
    );

    always_comb begin
        alu_z = '0;
        case (alu_op)
            3'b000: alu_z = alu_a & alu_b;
            3'b001: alu_z = alu_a | alu_b;
            3'b010: alu_z = alu_a + alu_b;
            3'b110: alu_z = alu_a - alu_b;
            3'b111: alu_z = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_z = '0;
        endcase
        alu_zero = alu_z == '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        int n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic resp(input string tag, input logic [31:0] res, input logic z,
                        input logic tk, input logic ill);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, out_result, res);
        chk({tag, "_zero"}, out_zero, z);
        chk({tag, "_taken"}, out_taken, tk);
        chk({tag, "_illegal"}, out_illegal, ill);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 0);
        chk({tag, "_idle"}, in_ready, 1);
        if (!ill && exp_ops < (1 << CW) - 1) exp_ops++;
        chk({tag, "_ops"}, ops_done, exp_ops);
    endtask

    task automatic run(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [2:0] op, input logic [31:0] res,
                       input logic z, input logic tk, input logic ill);
        issue(opc, f3, f7, rs1, rs2, imm);
        if (!ill) begin
            chk({tag, "_aluop"}, alu_op, op);
            chk({tag, "_exec_valid"}, out_valid, 0);
            tick();
        end
        resp(tag, res, z, tk, ill);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_flags", {out_zero, out_taken, out_illegal}, 0);
        chk("rst_ops", ops_done, 0);

        issue(7'h33, 3'b000, 7'h00, 32'd5, 32'd7, 32'd99);
        chk("add_a", alu_a, 5);
        chk("add_b", alu_b, 7);
        chk("add_op", alu_op, 3'b010);
        chk("add_busy", in_ready, 0);
        chk("add_lat1", out_valid, 0);
        tick();
        resp("add", 32'd12, 0, 0, 0);

        run("sub", 7'h33, 3'b000, 7'h20, 32'h8000_0000, 32'h8000_0000, 0, 3'b110, 0, 1, 0, 0);
        run("beq_t", 7'h63, 3'b000, 7'h00, 3, 3, 0, 3'b110, 0, 1, 1, 0);
        run("beq_nt", 7'h63, 3'b000, 7'h00, 3, 4, 0, 3'b110, 32'hFFFF_FFFF, 0, 0, 0);
        run("slti", 7'h13, 3'b010, 7'h20, 32'hFFFF_FFFF, 32'h55, 1, 3'b111, 1, 0, 0, 0);
        run("ill_opc", 7'h7F, 3'b000, 7'h00, 1, 2, 3, 3'b000, 0, 0, 0, 1);
        run("andi", 7'h13, 3'b111, 7'h00, 32'hF0F0, 32'h1, 32'hFF, 3'b000, 32'hF0, 0, 0, 0);
        run("or", 7'h33, 3'b110, 7'h00, 32'hF0, 32'h0F, 0, 3'b001, 32'hFF, 0, 0, 0);
        run("ld", 7'h03, 3'b010, 7'h00, 32'h1000, 32'h7, 32'hFFFF_FFFC, 3'b010, 32'hFFC, 0, 0, 0);
        run("st", 7'h23, 3'b010, 7'h00, 32'h20, 32'h7, 32'h8, 3'b010, 32'h28, 0, 0, 0);
        run("ill_sll", 7'h33, 3'b001, 7'h00, 1, 2, 3, 3'b000, 0, 0, 0, 1);
        run("ill_blt", 7'h63, 3'b100, 7'h00, 3, 4, 0, 3'b110, 0, 0, 0, 1);
`ifdef BRANCH_BNE_EN
        run("bne", 7'h63, 3'b001, 7'h00, 3, 4, 0, 3'b110, 32'hFFFF_FFFF, 0, 1, 0);
`else
        run("bne", 7'h63, 3'b001, 7'h00, 3, 4, 0, 3'b110, 0, 0, 0, 1);
`endif

        issue(7'h33, 3'b000, 7'h00, 32'd1, 32'd2, 0);
        tick();
        in_valid = 1'b1;
        in_opcode = 7'h33; in_rs1 = 32'd77;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_result", out_result, 3);
            chk("bp_busy", in_ready, 0);
            chk("bp_alu_a", alu_a, 1);
        end
        in_valid = 1'b0;
        resp("bp", 32'd3, 0, 0, 0);

        issue(7'h33, 3'b000, 7'h00, 32'd9, 32'd9, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ops = 0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ops", ops_done, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_alu_a", alu_a, 0);

        for (int i = 0; i < 17; i++)
            run("sat", 7'h33, 3'b000, 7'h00, i, 1, 0, 3'b010, i + 1, 0, 0, 0);
        chk("sat_hold", ops_done, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
